// File: rtl/cpu6_shift_unit.sv
// cpu6 execute-stage iterative shifter: shifts STEP bits per cycle
// and holds the pipeline until the result is ready.
module cpu6_shift_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN),
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            shft_lr,
  input  logic            shft_la,
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  shamt,
  input  logic            kill,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int SW = $clog2(STEP) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_acc;
  logic [SHW:0]    r_cnt;
  logic            r_dir;
  logic            r_ari;

  logic            w_accept;
  logic            w_last;
  logic [SW-1:0]   w_s;
  logic [XLEN-1:0] w_shifted;

  assign w_accept = (r_state == S_IDLE) & start & ~kill;
  assign w_last   = r_cnt <= (SHW+1)'(STEP);
  assign w_s      = w_last ? r_cnt[SW-1:0] : SW'(STEP);

  // Right shifts go through one extra fill bit so logical and
  // arithmetic share a single shifter.
  always_comb begin
    w_shifted = r_acc;
    if (r_dir) begin
      w_shifted = XLEN'($signed({r_ari & r_acc[XLEN-1], r_acc}) >>> w_s);
    end else begin
      w_shifted = r_acc << w_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (kill) begin
      w_next = S_IDLE;
    end
  end

  always_comb begin
    stall = resetn & (w_accept | ((r_state == S_SHIFT) & ~kill));
    done  = resetn & (r_state == S_DONE);
  end

  assign result = r_acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_dir <= 1'b0;
      r_ari <= 1'b0;
    end else if (w_accept) begin
      r_acc <= a;
      r_cnt <= {1'b0, shamt};
      r_dir <= shft_lr;
      r_ari <= shft_la & shft_lr;
    end else if ((r_state == S_SHIFT) && !kill) begin
      r_acc <= w_shifted;
      r_cnt <= r_cnt - (SHW+1)'(w_s);
    end
  end

endmodule
